// File: rtl/delay_timer_arbiter_if.sv
// delay_timer_arbiter_if: request/grant bundle for the shared delay timer.
interface delay_timer_arbiter_if #(parameter int Data_Width = 32);
  logic [3:0]              Req;
  logic [4*Data_Width-1:0] Load_Val;
  logic [3:0]              Cancel;
  logic [3:0]              Grant;
  logic [3:0]              Done;
  logic                    Busy;
  logic [Data_Width-1:0]   Remaining;
  modport master (output Req, Load_Val, Cancel, input Grant, Done, Busy, Remaining);
  modport slave  (input Req, Load_Val, Cancel, output Grant, Done, Busy, Remaining);
endinterface

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: round-robin arbiter lending one shared down-counter to four requesters.
// Completion is detected when the counter wraps past zero, so a load of V finishes V+2 cycles after grant.
module delay_timer_arbiter #(
  parameter int Data_Width = 32
) (
  input logic               Clk,
  input logic               Rst_n,
  delay_timer_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNT, FIN} state_t;
  state_t                state_q, state_d;
  logic [Data_Width-1:0] cnt_q, cnt_d;
  logic [3:0]            grant_q, grant_d;
  logic [3:0]            done_q, done_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            win, own;
  logic [Data_Width-1:0] lv_sel;
  always_comb begin
    win = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (bus.Req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  assign own    = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]};
  assign lv_sel = bus.Load_Val[win*Data_Width +: Data_Width];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE:
        if (|bus.Req) begin
          state_d = COUNT;
          cnt_d   = {1'b0, lv_sel[Data_Width-2:0]};
          grant_d = 4'b0001 << win;
        end
      COUNT:
        // wrap takes precedence over a simultaneous cancel
        if (cnt_q[Data_Width-1]) begin
          state_d = FIN;
          done_d  = grant_q;
        end else if (|(bus.Cancel & grant_q)) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = own + 2'd1;
        end else
          cnt_d = cnt_q - 1'b1;
      FIN: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = own + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
    end
  assign bus.Grant     = grant_q;
  assign bus.Done      = done_q;
  assign bus.Busy      = |grant_q;
  assign bus.Remaining = cnt_q;
endmodule

// File: tb/tb_delay_timer_arbiter.sv
// tb_delay_timer_arbiter: directed and random checks against a transaction-timing model.
module tb_delay_timer_arbiter;
  localparam int W = 32;
  localparam int OW = 4 + 4 + 1 + W;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic [W-1:0] lv[4];
  delay_timer_arbiter_if #(.Data_Width(W)) bus ();
  delay_timer_arbiter #(.Data_Width(W)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus.slave));
  assign bus.Load_Val = {lv[3], lv[2], lv[1], lv[0]};
  always #5 Clk = ~Clk;
  int errors = 0;
  int checks = 0;
  // model: owner (-1 idle), cycles t since grant edge, stripped load v, pointer, visible counter
  int owner, ptr, t;
  longint v;
  logic [W-1:0] m_rem;
  function automatic logic [OW-1:0] expv();
    logic [3:0] g;
    logic [3:0] d;
    g = (owner >= 0) ? 4'(1 << owner) : 4'b0;
    d = (owner >= 0 && longint'(t) == v + 2) ? g : 4'b0;
    return {g, d, |g, m_rem};
  endfunction
  function automatic logic [OW-1:0] obsv();
    return {bus.Grant, bus.Done, bus.Busy, bus.Remaining};
  endfunction
  task automatic model_reset();
    owner = -1; ptr = 0; t = 0; v = 0; m_rem = '0;
  endtask
  task automatic model_edge();
    if (owner < 0) begin
      if (bus.Req != 4'b0) begin
        for (int k = 3; k >= 0; k--)
          if (bus.Req[(ptr + k) % 4]) owner = (ptr + k) % 4;
        v = longint'(lv[owner] & 32'h7FFF_FFFF);
        t = 0;
        m_rem = W'(v);
      end
    end else if (longint'(t) <= v && bus.Cancel[owner]) begin
      ptr = (owner + 1) % 4;
      owner = -1;
    end else begin
      t++;
      if (longint'(t) == v + 3) begin
        ptr = (owner + 1) % 4;
        owner = -1;
      end else if (longint'(t) <= v + 1) m_rem = W'(v - longint'(t));
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    if (Rst_n) model_edge();
    #1;
  endtask
  task automatic do_reset();
    Rst_n = 1'b0;
    bus.Req = '0;
    bus.Cancel = '0;
    for (int i = 0; i < 4; i++) lv[i] = '0;
    model_reset();
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask
  task automatic drain();
    bus.Req = '0;
    bus.Cancel = '0;
    for (int c = 0; c < 300 && owner >= 0; c++) begin
      tick();
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL drain: got %h want %h", obsv(), expv());
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    Rst_n = 1'b0;
    #1;
    checks++;
    if (obsv() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obsv());
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    checks++;
    if (obsv() !== expv() || bus.Grant !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obsv(), expv());
    end
  endtask
  task automatic test_single();
    int done_at;
    do_reset();
    done_at = -1;
    lv[2] = 32'd3;
    bus.Req = 4'b0100;
    tick();
    bus.Req = 4'b0;
    checks++;
    if (bus.Grant !== 4'b0100 || obsv() !== expv()) begin
      errors++;
      $display("FAIL single_grant: got %h want %h", obsv(), expv());
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.Done != 4'b0) done_at = (done_at < 0) ? c : 99;
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL single_cycle%0d: got %h want %h", c, obsv(), expv());
      end
    end
    checks++;
    if (done_at != 5 || bus.Grant !== 4'b0) begin
      errors++;
      $display("FAIL single_done_time: got %0d grant %b want 5 grant 0000", done_at, bus.Grant);
    end
  endtask
  task automatic test_round_robin();
    int order[$];
    int rise[$];
    logic [3:0] prev;
    do_reset();
    bus.Req = 4'b1111;
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.Grant != 4'b0 && prev == 4'b0) begin
        order.push_back($clog2(bus.Grant));
        rise.push_back(c);
      end
      prev = bus.Grant;
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL rr_cycle%0d: got %h want %h", c, obsv(), expv());
      end
    end
    checks++;
    if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
      errors++;
      $display("FAIL rr_order: got %p want '{0,1,2,3,0}", order);
    end
    for (int i = 1; i < rise.size(); i++) begin
      checks++;
      if (rise[i] - rise[i-1] != 4) begin
        errors++;
        $display("FAIL rr_spacing%0d: got %0d want 4", i, rise[i] - rise[i-1]);
      end
    end
    drain();
  endtask
  task automatic test_cancel();
    bit hit;
    do_reset();
    lv[1] = 32'd100;
    bus.Req = 4'b0010;
    tick();
    bus.Req = 4'b1010;
    bus.Cancel = 4'b0001;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (bus.Remaining == 32'd50) hit = 1;
      else begin
        tick();
        checks++;
        if (obsv() !== expv()) begin
          errors++;
          $display("FAIL cancel_count: got %h want %h", obsv(), expv());
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL cancel_reach50: got %0d want 50", bus.Remaining);
    end
    bus.Cancel = 4'b0010;
    tick();
    bus.Cancel = 4'b0;
    checks++;
    if (bus.Grant !== 4'b0 || bus.Done !== 4'b0 || obsv() !== expv()) begin
      errors++;
      $display("FAIL cancel_drop: got %h want %h", obsv(), expv());
    end
    tick();
    checks++;
    if (bus.Grant !== 4'b1000 || obsv() !== expv()) begin
      errors++;
      $display("FAIL cancel_next: got %h want %h", obsv(), expv());
    end
    drain();
  endtask
  task automatic test_cancel_at_end();
    bit hit;
    do_reset();
    lv[0] = 32'd2;
    bus.Req = 4'b0001;
    tick();
    bus.Req = 4'b0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (bus.Remaining == 32'hFFFF_FFFF) hit = 1;
      else tick();
    end
    bus.Cancel = 4'b0001;
    tick();
    bus.Cancel = 4'b0;
    checks++;
    if (!hit || bus.Done !== 4'b0001 || obsv() !== expv()) begin
      errors++;
      $display("FAIL cancel_late: got %h want %h", obsv(), expv());
    end
    drain();
  endtask
  task automatic test_async_reset();
    bit hit;
    do_reset();
    lv[0] = 32'd30;
    bus.Req = 4'b0001;
    tick();
    bus.Req = 4'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (bus.Remaining == 32'd20) hit = 1;
      else tick();
    end
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (!hit || obsv() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", obsv());
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    bus.Req = 4'b1000;
    tick();
    bus.Req = 4'b0;
    checks++;
    if (bus.Grant !== 4'b1000 || obsv() !== expv()) begin
      errors++;
      $display("FAIL async_regrant: got %h want %h", obsv(), expv());
    end
    drain();
  endtask
  task automatic test_msb();
    int done_at;
    do_reset();
    done_at = -1;
    lv[0] = 32'h8000_0005;
    bus.Req = 4'b0001;
    tick();
    bus.Req = 4'b0;
    checks++;
    if (bus.Remaining !== 32'd5) begin
      errors++;
      $display("FAIL msb_load: got %h want 00000005", bus.Remaining);
    end
    for (int c = 1; c <= 10 && done_at < 0; c++) begin
      tick();
      if (bus.Done != 4'b0) done_at = c;
    end
    checks++;
    if (done_at != 7) begin
      errors++;
      $display("FAIL msb_done_time: got %0d want 7", done_at);
    end
    drain();
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.Req = 4'($urandom_range(0, 15));
      bus.Cancel = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      for (int i = 0; i < 4; i++)
        lv[i] = ($urandom_range(0, 7) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 6))) : 32'($urandom_range(0, 12));
      tick();
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h want %h", c, obsv(), expv());
      end
      checks++;
      if (!$onehot0(bus.Grant) || !$onehot0(bus.Done)) begin
        errors++;
        $display("FAIL random_onehot%0d: grant %b done %b want onehot0", c, bus.Grant, bus.Done);
      end
    end
    drain();
  endtask
  initial begin
    bus.Req = '0;
    bus.Cancel = '0;
    for (int i = 0; i < 4; i++) lv[i] = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_cancel();
    test_cancel_at_end();
    test_async_reset();
    test_msb();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
